// File: rtl/netwalk_pkg.sv
// netwalk_pkg: shared flow-table widths and programmer FSM state encoding.
package netwalk_pkg;
   localparam int NW_TCAM_ADDR_WIDTH       = 6;
   localparam int NW_DPL_MATCH_FIELD_WIDTH = 356;
   localparam int NW_ACTION_FLAG_WIDTH     = 16;
   localparam int NW_ACTION_SET_WIDTH      = 356;
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WR_MATCH  = 2'd1,
      ST_WR_ACTION = 2'd2,
      ST_DONE      = 2'd3
   } prog_state_t;
endpackage

// File: rtl/netwalk_req_buffer.sv
// netwalk_req_buffer: one-entry request holding buffer; a push into a full buffer
// that is not being popped in the same cycle is refused and flagged as a drop.
module netwalk_req_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         drop
);
   assign drop = push && valid && !pop;
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (pop) valid <= 1'b0;
         if (push && (!valid || pop)) begin
            valid <= 1'b1;
            data  <= push_data;
         end
      end
   end
endmodule

// File: rtl/netwalk_flow_table_programmer.sv
// netwalk_flow_table_programmer: installs flow entries into TCAM and action memory.
// Define NETWALK_FLOW_REPLACE_EN to overwrite the oldest entry when the table is full.
module netwalk_flow_table_programmer
   import netwalk_pkg::*;
#(
   parameter int TCAM_ADDR_WIDTH       = NW_TCAM_ADDR_WIDTH,
   parameter int DPL_MATCH_FIELD_WIDTH = NW_DPL_MATCH_FIELD_WIDTH,
   parameter int ACTION_FLAG_WIDTH     = NW_ACTION_FLAG_WIDTH,
   parameter int ACTION_SET_WIDTH      = NW_ACTION_SET_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             glbl_program_en,
   input  logic                             of_dpl_program_enable,
   input  logic [DPL_MATCH_FIELD_WIDTH-1:0] of_dpl_program_data,
   input  logic [DPL_MATCH_FIELD_WIDTH-1:0] of_dpl_program_mask,
   input  logic [ACTION_FLAG_WIDTH-1:0]     of_dpl_action_flag,
   input  logic [ACTION_SET_WIDTH-1:0]      of_dpl_action_set,
   input  logic                             flow_table_flush,
   output logic                             tcam_wr_en,
   output logic [TCAM_ADDR_WIDTH-1:0]       tcam_wr_addr,
   output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_wr_data,
   output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_wr_mask,
   output logic                             act_wr_en,
   output logic [TCAM_ADDR_WIDTH-1:0]       act_wr_addr,
   output logic [ACTION_FLAG_WIDTH-1:0]     act_wr_flag,
   output logic [ACTION_SET_WIDTH-1:0]      act_wr_set,
   output logic                             prog_done,
   output logic                             prog_busy,
   output logic                             table_full,
   output logic [TCAM_ADDR_WIDTH:0]         entry_count,
   output logic [15:0]                      drop_count
);
   localparam int AW = TCAM_ADDR_WIDTH;
   localparam int RW = 2 * DPL_MATCH_FIELD_WIDTH + ACTION_FLAG_WIDTH + ACTION_SET_WIDTH;
   localparam logic [AW:0] TABLE_MAX = (AW+1)'(1) << AW;
   prog_state_t state, state_n;
   logic [RW-1:0] req_vec, buf_data, cand;
   logic buf_valid, buf_drop, buf_valid_n;
   logic flush_pend, flush_now, take, start, discard, pop, push;
   logic [AW-1:0] wr_ptr, eff_ptr;
   logic [AW:0] eff_cnt, cnt_n;
   logic [ACTION_FLAG_WIDTH-1:0] work_flag;
   logic [ACTION_SET_WIDTH-1:0] work_set;
   assign req_vec = {of_dpl_program_data, of_dpl_program_mask, of_dpl_action_flag, of_dpl_action_set};
   netwalk_req_buffer #(.W(RW)) u_req_buffer (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (req_vec),
      .valid     (buf_valid),
      .data      (buf_data),
      .drop      (buf_drop)
   );
   // An idle block with an empty buffer takes a new request straight into the write,
   // which is what gives the one-cycle request-to-tcam_wr_en latency.
   always_comb begin
      flush_now = state == ST_IDLE && (flow_table_flush || flush_pend);
      eff_ptr   = flush_now ? '0 : wr_ptr;
      eff_cnt   = flush_now ? '0 : entry_count;
      cand      = buf_valid ? buf_data : req_vec;
      take      = state == ST_IDLE && !glbl_program_en && (buf_valid || of_dpl_program_enable);
`ifdef NETWALK_FLOW_REPLACE_EN
      start     = take;
`else
      start     = take && eff_cnt != TABLE_MAX;
`endif
      discard     = take && !start;
      pop         = take && buf_valid;
      push        = of_dpl_program_enable && !(take && !buf_valid);
      buf_valid_n = (buf_valid && !pop) || (push && (!buf_valid || pop));
      cnt_n       = state == ST_WR_ACTION ? entry_count + (AW+1)'(entry_count != TABLE_MAX) : eff_cnt;
      state_n     = state == ST_IDLE      ? (start ? ST_WR_MATCH : ST_IDLE) :
                    state == ST_WR_MATCH  ? ST_WR_ACTION :
                    state == ST_WR_ACTION ? ST_DONE : ST_IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tcam_wr_en   <= 1'b0;
         tcam_wr_addr <= '0;
         tcam_wr_data <= '0;
         tcam_wr_mask <= '0;
         act_wr_en    <= 1'b0;
         act_wr_addr  <= '0;
         act_wr_flag  <= '0;
         act_wr_set   <= '0;
         work_flag    <= '0;
         work_set     <= '0;
         prog_done    <= 1'b0;
         prog_busy    <= 1'b0;
         table_full   <= 1'b0;
         entry_count  <= '0;
         drop_count   <= '0;
         wr_ptr       <= '0;
         flush_pend   <= 1'b0;
      end else begin
         tcam_wr_en  <= start;
         act_wr_en   <= state == ST_WR_MATCH;
         prog_done   <= state == ST_WR_ACTION;
         prog_busy   <= state_n != ST_IDLE || buf_valid_n;
         entry_count <= cnt_n;
         table_full  <= cnt_n == TABLE_MAX;
         wr_ptr      <= state == ST_WR_ACTION ? wr_ptr + 1'b1 : eff_ptr;
         flush_pend  <= (flow_table_flush || flush_pend) && !flush_now;
         if ((discard || buf_drop) && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         if (start) begin
            tcam_wr_addr <= eff_ptr;
            {tcam_wr_data, tcam_wr_mask, work_flag, work_set} <= cand;
         end
         if (state == ST_WR_MATCH) begin
            act_wr_addr <= tcam_wr_addr;
            act_wr_flag <= work_flag;
            act_wr_set  <= work_set;
         end
      end
   end
endmodule
